ysyx_24120013_mem_arbiter: RTL and testbench

- Two-requester arbiter that shares one memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) of the ysyx_24120013 core.
- Accepts one transaction at a time, forwards it to memory and routes the response back to the owner.
- Grants by round-robin, with a timeout guard against a memory that never answers.
- Sits between the IFU/LSU and the memory model in the top level.

---
 rtl/ysyx_24120013_mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_ysyx_24120013_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24120013_mem_arbiter.sv
// Round-robin arbiter that shares one memory port between the IFU and the LSU.
// Handles one transaction at a time and aborts it if memory stays silent for too long.
module ysyx_24120013_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_WIDTH-1:0] ifu_resp_data,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [3:0]            lsu_wmask,
  output logic                  lsu_resp_valid,
  output logic [DATA_WIDTH-1:0] lsu_resp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_SAT  = '1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IFU, OWN_LSU} owner_e;

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                last_q, last_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wmask_q, wmask_d;
  logic                  ifu_rv_q, ifu_rv_d;
  logic [DATA_WIDTH-1:0] ifu_rd_q, ifu_rd_d;
  logic                  lsu_rv_q, lsu_rv_d;
  logic [DATA_WIDTH-1:0] lsu_rd_q, lsu_rd_d;
  logic                  terr_q, terr_d;
  logic                  grant_ifu, grant_lsu;
  logic                  finish, resp_hit;
  logic [DATA_WIDTH-1:0] resp_val;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    timer_d   = timer_q;
    addr_d    = addr_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    ifu_rv_d  = 1'b0;
    ifu_rd_d  = ifu_rd_q;
    lsu_rv_d  = 1'b0;
    lsu_rd_d  = lsu_rd_q;
    terr_d    = 1'b0;
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    finish    = 1'b0;
    resp_hit  = 1'b0;
    resp_val  = '0;

    case (state_q)
      S_IDLE: begin
        // On contention the requester that did not win last time goes first.
        if (ifu_req_valid && lsu_req_valid) begin
          grant_lsu = (last_q == OWN_IFU);
          grant_ifu = (last_q != OWN_IFU);
        end else begin
          grant_ifu = ifu_req_valid;
          grant_lsu = lsu_req_valid;
        end
        if (grant_ifu) begin
          addr_d  = ifu_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = 4'h0;
          owner_d = OWN_IFU;
          last_d  = OWN_IFU;
          timer_d = '0;
          state_d = S_REQ;
        end else if (grant_lsu) begin
          addr_d  = lsu_addr;
          wen_d   = lsu_wen;
          wdata_d = lsu_wdata;
          wmask_d = lsu_wmask;
          owner_d = OWN_LSU;
          last_d  = OWN_LSU;
          timer_d = '0;
          state_d = S_REQ;
        end
      end
      S_REQ, S_WAIT: begin
        if (timer_q != TIMER_SAT) timer_d = timer_q + TW'(1);
        // A response in the final cycle still beats the timeout.
        if (state_q == S_WAIT && mem_resp_valid) begin
          finish   = 1'b1;
          resp_hit = 1'b1;
          resp_val = wen_q ? '0 : mem_resp_data;
        end else if (timer_q == TIMER_LAST) begin
          finish = 1'b1;
          terr_d = 1'b1;
        end else if (state_q == S_REQ && mem_req_ready) begin
          state_d = S_WAIT;
        end
        if (finish) begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
          if (owner_q == OWN_IFU) begin
            ifu_rv_d = 1'b1;
            ifu_rd_d = resp_val;
          end else if (owner_q == OWN_LSU) begin
            lsu_rv_d = 1'b1;
            lsu_rd_d = resp_val;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_NONE;
      last_q   <= OWN_IFU;
      timer_q  <= '0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= 4'h0;
      ifu_rv_q <= 1'b0;
      ifu_rd_q <= '0;
      lsu_rv_q <= 1'b0;
      lsu_rd_q <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      timer_q  <= timer_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      ifu_rv_q <= ifu_rv_d;
      ifu_rd_q <= ifu_rd_d;
      lsu_rv_q <= lsu_rv_d;
      lsu_rd_q <= lsu_rd_d;
      terr_q   <= terr_d;
    end
  end

  // Ready is held low while reset is asserted so every output reads zero.
  assign ifu_req_ready  = grant_ifu & ~rst;
  assign lsu_req_ready  = grant_lsu & ~rst;
  assign mem_req_valid  = (state_q == S_REQ);
  assign busy           = (state_q != S_IDLE);
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign ifu_resp_valid = ifu_rv_q;
  assign ifu_resp_data  = ifu_rd_q;
  assign lsu_resp_valid = lsu_rv_q;
  assign lsu_resp_data  = lsu_rd_q;
  assign timeout_err    = terr_q;

endmodule

// File: tb/tb_ysyx_24120013_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter: cycle table plus timeout and reset sequences.
module tb_ysyx_24120013_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  localparam logic [6:0] F_IR = 7'b1000000;
  localparam logic [6:0] F_LR = 7'b0100000;
  localparam logic [6:0] F_MQ = 7'b0010000;
  localparam logic [6:0] F_BZ = 7'b0001000;
  localparam logic [6:0] F_IV = 7'b0000100;
  localparam logic [6:0] F_LV = 7'b0000010;
  localparam logic [6:0] F_TE = 7'b0000001;

  logic          clk;
  logic          rst;
  logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [AW-1:0] ifu_addr;
  logic [DW-1:0] ifu_resp_data;
  logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_resp_data;
  logic [3:0]    lsu_wmask;
  logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_resp_data;
  logic [3:0]    mem_wmask;
  logic          busy, timeout_err;

  int errors = 0;
  int checks = 0;

  ysyx_24120013_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        lv;
    logic [31:0] la;
    logic        lw;
    logic [31:0] ld;
    logic [3:0]  lm;
    logic        mrdy;
    logic        mrv;
    logic [31:0] mrd;
    logic [6:0]  ef;
    logic [31:0] ea;
    logic        ew;
    logic [31:0] ed;
    logic [3:0]  em;
    logic [31:0] er;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic iv, input logic [31:0] ia, input logic lv, input logic [31:0] la,
                      input logic lw, input logic [31:0] ld, input logic [3:0] lm,
                      input logic mrdy, input logic mrv, input logic [31:0] mrd,
                      input logic [6:0] ef, input logic [31:0] ea, input logic ew,
                      input logic [31:0] ed, input logic [3:0] em, input logic [31:0] er);
    vec_t v;
    v.iv = iv; v.ia = ia; v.lv = lv; v.la = la; v.lw = lw; v.ld = ld; v.lm = lm;
    v.mrdy = mrdy; v.mrv = mrv; v.mrd = mrd;
    v.ef = ef; v.ea = ea; v.ew = ew; v.ed = ed; v.em = em; v.er = er;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] flags();
    return {ifu_req_ready, lsu_req_ready, mem_req_valid, busy,
            ifu_resp_valid, lsu_resp_valid, timeout_err};
  endfunction

  task automatic clear_inputs();
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;

    // Both requesters held: LSU, IFU, LSU, IFU. Memory ready at once, answers next cycle.
    addv(1,32'h200,1,32'h100,0,0,0, 0,0,0,          F_LR,        0,0,0,0,0);
    addv(1,32'h200,1,32'h100,0,0,0, 1,0,0,          F_MQ|F_BZ,   32'h100,0,0,0,0);
    addv(1,32'h200,1,32'h100,0,0,0, 0,1,32'hA1,     F_BZ,        0,0,0,0,0);
    addv(1,32'h200,1,32'h100,0,0,0, 0,0,0,          F_IR|F_LV,   0,0,0,0,32'hA1);
    addv(1,32'h200,1,32'h100,0,0,0, 1,0,0,          F_MQ|F_BZ,   32'h200,0,0,0,0);
    addv(1,32'h200,1,32'h100,0,0,0, 0,1,32'hB2,     F_BZ,        0,0,0,0,0);
    addv(1,32'h200,1,32'h100,0,0,0, 0,0,0,          F_LR|F_IV,   0,0,0,0,32'hB2);
    addv(1,32'h200,1,32'h100,0,0,0, 1,0,0,          F_MQ|F_BZ,   32'h100,0,0,0,0);
    addv(1,32'h200,1,32'h100,0,0,0, 0,1,32'hC3,     F_BZ,        0,0,0,0,0);
    addv(1,32'h200,1,32'h100,0,0,0, 0,0,0,          F_IR|F_LV,   0,0,0,0,32'hC3);
    addv(1,32'h200,1,32'h100,0,0,0, 1,0,0,          F_MQ|F_BZ,   32'h200,0,0,0,0);
    addv(1,32'h200,1,32'h100,0,0,0, 0,1,32'hD4,     F_BZ,        0,0,0,0,0);
    addv(0,0,0,0,0,0,0,             0,0,0,          F_IV,        0,0,0,0,32'hD4);
    // IFU fetch alone.
    addv(1,32'h80000000,0,0,0,0,0,  0,0,0,          F_IR,        0,0,0,0,0);
    addv(0,0,0,0,0,0,0,             1,0,0,          F_MQ|F_BZ,   32'h80000000,0,0,0,0);
    addv(0,0,0,0,0,0,0,             0,0,0,          F_BZ,        0,0,0,0,0);
    addv(0,0,0,0,0,0,0,             0,1,32'h413,    F_BZ,        0,0,0,0,0);
    addv(0,0,0,0,0,0,0,             0,0,0,          F_IV,        0,0,0,0,32'h413);
    addv(0,0,0,0,0,0,0,             0,0,0,          7'b0,        0,0,0,0,0);
    // LSU write with memory stalling three cycles; request fields change after accept.
    addv(0,0,1,32'h80001000,1,32'hDEADBEEF,4'hF, 0,0,0, F_LR, 0,0,0,0,0);
    addv(0,0,0,0,0,0,0, 0,0,0, F_MQ|F_BZ, 32'h80001000,1,32'hDEADBEEF,4'hF,0);
    addv(0,0,0,0,0,0,0, 0,0,0, F_MQ|F_BZ, 32'h80001000,1,32'hDEADBEEF,4'hF,0);
    addv(0,0,0,0,0,0,0, 0,0,0, F_MQ|F_BZ, 32'h80001000,1,32'hDEADBEEF,4'hF,0);
    addv(0,0,0,0,0,0,0, 1,0,0, F_MQ|F_BZ, 32'h80001000,1,32'hDEADBEEF,4'hF,0);
    addv(0,0,0,0,0,0,0, 0,1,32'h12345678, F_BZ, 0,0,0,0,0);
    addv(0,0,0,0,0,0,0, 0,0,0, F_LV, 0,0,0,0,32'h0);
    addv(0,0,0,0,0,0,0, 0,0,0, 7'b0, 0,0,0,0,0);

    // Reset state.
    tick();
    chk("reset flags", {25'b0, flags()}, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    chk("reset wen/wmask", {27'b0, mem_wen, mem_wmask}, 32'h0);
    chk("reset resp data", ifu_resp_data | lsu_resp_data, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      ifu_req_valid = vq[i].iv; ifu_addr = vq[i].ia;
      lsu_req_valid = vq[i].lv; lsu_addr = vq[i].la; lsu_wen = vq[i].lw;
      lsu_wdata = vq[i].ld; lsu_wmask = vq[i].lm;
      mem_req_ready = vq[i].mrdy; mem_resp_valid = vq[i].mrv; mem_resp_data = vq[i].mrd;
      #1;
      chk($sformatf("v%0d flags", i), {25'b0, flags()}, {25'b0, vq[i].ef});
      if (vq[i].ef[4]) begin
        chk($sformatf("v%0d mem_addr", i), mem_addr, vq[i].ea);
        chk($sformatf("v%0d mem_wdata", i), mem_wdata, vq[i].ed);
        chk($sformatf("v%0d wen/wmask", i), {27'b0, mem_wen, mem_wmask}, {27'b0, vq[i].ew, vq[i].em});
      end
      if (vq[i].ef[2])
        chk($sformatf("v%0d ifu_resp_data", i), ifu_resp_data, vq[i].er);
      if (vq[i].ef[1])
        chk($sformatf("v%0d lsu_resp_data", i), lsu_resp_data, vq[i].er);
      tick();
    end

    // Timeout: memory accepts but never answers.
    clear_inputs();
    ifu_req_valid = 1; ifu_addr = 32'h80000100;
    #1; chk("to accept ifu", {31'b0, ifu_req_ready}, 32'h1);
    tick();
    ifu_req_valid = 0; mem_req_ready = 1;
    #1; chk("to req", {31'b0, mem_req_valid}, 32'h1);
    tick();
    mem_req_ready = 0;
    for (int k = 1; k < TO; k++) begin
      #1; chk($sformatf("to wait%0d busy/te/rv", k),
              {29'b0, busy, timeout_err, ifu_resp_valid}, 32'h4);
      tick();
    end
    lsu_req_valid = 1; lsu_addr = 32'h80002000; lsu_wen = 0;
    #1;
    chk("to pulse flags", {25'b0, flags()}, {25'b0, F_LR | F_IV | F_TE});
    chk("to resp data", ifu_resp_data, 32'h0);
    tick();
    lsu_req_valid = 0; mem_req_ready = 1;
    #1;
    chk("to after flags", {25'b0, flags()}, {25'b0, F_MQ | F_BZ});
    chk("to next addr", mem_addr, 32'h80002000);
    tick();

    // Response lands in the cycle the timeout would fire.
    mem_req_ready = 0;
    for (int k = 1; k < TO - 1; k++) begin
      #1; chk($sformatf("race wait%0d rv", k), {31'b0, lsu_resp_valid}, 32'h0);
      tick();
    end
    mem_resp_valid = 1; mem_resp_data = 32'h55AA0001;
    #1; tick();
    mem_resp_valid = 0; mem_resp_data = '0;
    #1;
    chk("race flags", {25'b0, flags()}, {25'b0, F_LV});
    chk("race data", lsu_resp_data, 32'h55AA0001);
    tick();
    chk("race pulse once", {25'b0, flags()}, 32'h0);

    // Reset asserted while waiting for a response.
    ifu_req_valid = 1; ifu_addr = 32'h80000200;
    #1; tick();
    ifu_req_valid = 0; mem_req_ready = 1;
    #1; tick();
    mem_req_ready = 0;
    #1; chk("rst pre busy", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst flags", {25'b0, flags()}, 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst resp data", ifu_resp_data | lsu_resp_data, 32'h0);
    tick();
    rst = 1'b0;
    mem_resp_valid = 1; mem_resp_data = 32'hBAD0BAD0;
    #1; tick();
    mem_resp_valid = 0;
    #1;
    chk("rst stale resp", {25'b0, flags()}, 32'h0);
    ifu_req_valid = 1; ifu_addr = 32'h80000300;
    #1; chk("rst new accept", {25'b0, flags()}, {25'b0, F_IR});
    tick();
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
